// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the RAM loader: FSM state encoding, the packed
// control-output bundle and the phase-counter width function.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_CPU_RST,
    ST_RUN,
    ST_HALT
  } ldr_state_t;

  typedef struct packed {
    logic s_ready;
    logic sw4;
    logic prog;
    logic sw8;
    logic clk_en;
    logic busy;
    logic halted;
  } ldr_ctl_t;

  function automatic int phase_width(input int setup_cyc, input int we_cyc, input int rst_cyc);
    int m;
    m = setup_cyc;
    if (we_cyc > m) m = we_cyc;
    if (rst_cyc > m) m = rst_cyc;
    return $clog2(m) + 1;
  endfunction

  // Control outputs as a pure function of the state being entered.
  function automatic ldr_ctl_t decode_ctl(input ldr_state_t st);
    ldr_ctl_t c;
    c = '{s_ready: 1'b0, sw4: 1'b1, prog: 1'b0, sw8: 1'b1,
          clk_en: 1'b0, busy: 1'b0, halted: 1'b0};
    case (st)
      ST_ACCEPT:  begin c.s_ready = 1'b1; c.busy = 1'b1; end
      ST_SETUP:   c.busy = 1'b1;
      ST_WRITE:   begin c.sw4 = 1'b0; c.busy = 1'b1; end
      ST_HOLD:    c.busy = 1'b1;
      ST_CPU_RST: begin c.prog = 1'b1; c.clk_en = 1'b1; c.busy = 1'b1; end
      ST_RUN:     begin c.prog = 1'b1; c.sw8 = 1'b0; end
      ST_HALT:    begin c.prog = 1'b1; c.sw8 = 1'b0; c.halted = 1'b1; end
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram_loader_phase_timer.sv
// Loadable down-counter timing the SETUP, WRITE and CPU_RST phases.
// Loading value V makes done rise on the V-th cycle after the load edge.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q > W'(1))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/ram_loader.sv
// Streams (address, data) words into the computer's RAM via its manual switches,
// then resets and runs the CPU until it halts.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int N         = 8,
  parameter int A         = 4,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 2,
  parameter int RST_CYC   = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [A-1:0] s_addr,
  input  logic [N-1:0] s_data,
  input  logic         s_last,
  input  logic         hlt,
  output logic [A-1:0] sw_mar,
  output logic [N-1:0] sw_dat,
  output logic         sw4,
  output logic         prog,
  output logic         sw8,
  output logic         cpu_clk_en,
  output logic         busy,
  output logic         halted,
  output logic [A:0]   wcount
);

  localparam int       PW   = phase_width(SETUP_CYC, WE_CYC, RST_CYC);
  localparam logic [A:0] WMAX = {1'b1, {A{1'b0}}};

  ldr_state_t   state_q, state_d;
  ldr_ctl_t     ctl_q, ctl_d;
  logic [A-1:0] sw_mar_q, sw_mar_d;
  logic [N-1:0] sw_dat_q, sw_dat_d;
  logic [A:0]   wcount_q, wcount_d;
  logic         last_q, last_d;
  logic         tmr_load, tmr_done;
  logic [PW-1:0] tmr_val;

  phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d  = state_q;
    sw_mar_d = sw_mar_q;
    sw_dat_d = sw_dat_q;
    wcount_d = wcount_q;
    last_d   = last_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_ACCEPT;
        wcount_d = '0;
      end
      ST_ACCEPT: if (s_valid) begin
        state_d  = ST_SETUP;
        sw_mar_d = s_addr;
        sw_dat_d = s_data;
        last_d   = s_last;
        tmr_load = 1'b1;
        tmr_val  = PW'(SETUP_CYC);
      end
      ST_SETUP: if (tmr_done) begin
        state_d  = ST_WRITE;
        tmr_load = 1'b1;
        tmr_val  = PW'(WE_CYC);
      end
      ST_WRITE: if (tmr_done) state_d = ST_HOLD;
      ST_HOLD: begin
        if (wcount_q != WMAX) wcount_d = wcount_q + 1'b1;
        if (last_q) begin
          state_d  = ST_CPU_RST;
          tmr_load = 1'b1;
          tmr_val  = PW'(RST_CYC);
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_CPU_RST: if (tmr_done) state_d = ST_RUN;
      ST_RUN: begin
        if (start) begin
          state_d  = ST_ACCEPT;
          wcount_d = '0;
        end else if (hlt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: if (start) begin
        state_d  = ST_ACCEPT;
        wcount_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    ctl_d = decode_ctl(state_d);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      ctl_q    <= decode_ctl(ST_IDLE);
      sw_mar_q <= '0;
      sw_dat_q <= '0;
      wcount_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      sw_mar_q <= sw_mar_d;
      sw_dat_q <= sw_dat_d;
      wcount_q <= wcount_d;
      last_q   <= last_d;
    end
  end

  assign s_ready = ctl_q.s_ready;
  assign sw4     = ctl_q.sw4;
  assign prog    = ctl_q.prog;
  assign sw8     = ctl_q.sw8;
  assign busy    = ctl_q.busy;
  assign halted  = ctl_q.halted;
  assign sw_mar  = sw_mar_q;
  assign sw_dat  = sw_dat_q;
  assign wcount  = wcount_q;
  // In RUN the enable drops combinationally with hlt so the CPU sees no edge after halting.
  assign cpu_clk_en = ctl_q.clk_en | ((state_q == ST_RUN) & ~hlt);

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural RAM and a tiny SAP-1 style CPU.
module tb_ram_loader;

  localparam int N = 8;
  localparam int A = 4;

  localparam logic [6:0] C_IDLE   = 7'b0101000;
  localparam logic [6:0] C_ACCEPT = 7'b1101010;
  localparam logic [6:0] C_SETUP  = 7'b0101010;
  localparam logic [6:0] C_WRITE  = 7'b0001010;
  localparam logic [6:0] C_CPURST = 7'b0111110;
  localparam logic [6:0] C_RUN    = 7'b0110100;
  localparam logic [6:0] C_HALT   = 7'b0110001;

  logic         clk = 1'b0;
  logic         clr, start, s_valid, s_last;
  logic [A-1:0] s_addr;
  logic [N-1:0] s_data;
  logic         s_ready, sw4, prog, sw8, cpu_clk_en, busy, halted;
  logic [A-1:0] sw_mar;
  logic [N-1:0] sw_dat;
  logic [A:0]   wcount;
  logic         hlt;

  ram_loader dut (
    .clk(clk), .clr(clr), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .s_last(s_last), .hlt(hlt),
    .sw_mar(sw_mar), .sw_dat(sw_dat), .sw4(sw4), .prog(prog), .sw8(sw8),
    .cpu_clk_en(cpu_clk_en), .busy(busy), .halted(halted), .wcount(wcount)
  );

  always #5 clk = ~clk;

  // {s_ready, sw4, prog, sw8, cpu_clk_en, busy, halted}
  logic [6:0] ctl;
  assign ctl = {s_ready, sw4, prog, sw8, cpu_clk_en, busy, halted};

  // RAM and CPU model; the CPU executes one instruction per enabled edge.
  logic [7:0] ram [16];
  int         we_cycles;
  logic [3:0] pc;
  logic [7:0] acc, out_reg, ir;
  logic       cpu_hlt;
  assign hlt = cpu_hlt;
  assign ir  = ram[pc];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      we_cycles <= 0;
    end else if (!prog && !sw4) begin
      ram[sw_mar] <= sw_dat;
      we_cycles   <= we_cycles + 1;
    end
    if (clr) begin
      pc <= '0; acc <= '0; out_reg <= '0; cpu_hlt <= 1'b0;
    end else if (cpu_clk_en) begin
      if (sw8) begin
        pc <= '0; acc <= '0; out_reg <= '0; cpu_hlt <= 1'b0;
      end else begin
        pc <= pc + 1'b1;
        case (ir[7:4])
          4'h0: acc <= ram[ir[3:0]];
          4'h1: acc <= acc + ram[ir[3:0]];
          4'h2: acc <= acc - ram[ir[3:0]];
          4'hE: out_reg <= acc;
          4'hF: cpu_hlt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_prev  = 0;
  int hs_now   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Presents one word and returns at the negedge after the handshake edge (state SETUP).
  task automatic send(input logic [3:0] a, input logic [7:0] d, input logic l, input bit drop);
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = l;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin
        hs_prev = hs_now;
        hs_now  = cyc;
        @(negedge clk);
        if (drop) s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("handshake_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_hlt;
    clr = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_addr = '0; s_data = '0;
    tick(3);
    clr = 1'b0;

    // Reset values
    check("reset_ctl", ctl, C_IDLE);
    check("reset_mar", sw_mar, 0);
    check("reset_dat", sw_dat, 0);
    check("reset_wcount", wcount, 0);

    // Single-word session
    do_start();
    check("accept_ctl", ctl, C_ACCEPT);
    send(4'd3, 8'h2E, 1'b1, 1'b1);
    check("setup_ctl", ctl, C_SETUP);
    tick(); check("write1_ctl", ctl, C_WRITE);
    check("write_mar", sw_mar, 3);
    check("write_dat", sw_dat, 8'h2E);
    tick(); check("write2_ctl", ctl, C_WRITE);
    tick(); check("hold_ctl", ctl, C_SETUP);
    tick(); check("cpurst1_ctl", ctl, C_CPURST);
    check("single_wcount", wcount, 1);
    tick(); check("cpurst2_ctl", ctl, C_CPURST);
    tick(); check("run_ctl", ctl, C_RUN);
    check("single_ram3", ram[3], 8'h2E);
    check("single_we_cycles", we_cycles, 2);

    // Program load with s_valid held high, then run to halt
    do_clr();
    check("clr_ctl", ctl, C_IDLE);
    do_start();
    send(4'd0, 8'h0E, 1'b0, 1'b0);
    send(4'd1, 8'h1F, 1'b0, 1'b0);
    check("gap_w2", hs_now - hs_prev, 5);
    send(4'd2, 8'hE0, 1'b0, 1'b0);
    check("gap_w3", hs_now - hs_prev, 5);
    send(4'd3, 8'hF0, 1'b0, 1'b0);
    check("gap_w4", hs_now - hs_prev, 5);
    send(4'd14, 8'h1C, 1'b0, 1'b0);
    check("gap_w5", hs_now - hs_prev, 5);
    send(4'd15, 8'h0E, 1'b1, 1'b1);
    check("gap_w6", hs_now - hs_prev, 5);
    seen_hlt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hlt && !seen_hlt) begin
        seen_hlt = 1'b1;
        check("clk_en_on_hlt", cpu_clk_en, 0);
      end
      if (halted) break;
    end
    check("halted", halted, 1);
    check("halt_ctl", ctl, C_HALT);
    check("cpu_out", out_reg, 8'h2A);
    check("cpu_pc_frozen", pc, 4);
    check("prog_wcount", wcount, 6);

    // New session from HALT, 17 words with address 5 written twice
    do_start();
    check("restart_ctl", ctl, C_ACCEPT);
    check("restart_wcount", wcount, 0);
    send(4'd5, 8'h11, 1'b0, 1'b1);
    send(4'd5, 8'h22, 1'b0, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      logic [3:0] a;
      a = (i == 5) ? 4'd6 : 4'(i);
      send(a, 8'(i), (i == 16), 1'b1);
    end
    tick(4);
    check("sat_ctl", ctl, C_CPURST);
    check("sat_wcount", wcount, 16);
    check("last_write_wins", ram[5], 8'h22);

    // Gaps on s_valid and s_data changes during WRITE
    do_clr();
    do_start();
    tick(4);
    check("nogo_ctl", ctl, C_ACCEPT);
    check("nogo_we", we_cycles, 0);
    send(4'd7, 8'h55, 1'b0, 1'b1);
    tick();
    s_data = 8'hAA; s_valid = 1'b1;
    tick();
    check("dat_stable", sw_dat, 8'h55);
    s_valid = 1'b0;
    tick(4);
    check("gap_ctl", ctl, C_ACCEPT);
    check("gap_we", we_cycles, 2);
    check("gap_ram7", ram[7], 8'h55);
    check("gap_wcount", wcount, 1);

    // start in SETUP ignored, clr during WRITE aborts, restart is clean
    send(4'd9, 8'h66, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("start_ignored", ctl, C_WRITE);
    do_clr();
    check("abort_ctl", ctl, C_IDLE);
    check("abort_wcount", wcount, 0);
    check("abort_mar", sw_mar, 0);
    do_start();
    send(4'd2, 8'h77, 1'b1, 1'b1);
    tick(4);
    check("recover_ctl", ctl, C_CPURST);
    check("recover_wcount", wcount, 1);
    check("recover_ram2", ram[2], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
